vga_timing: RTL and testbench

//  Raster timing generator for the screensaver display path; feeds every image generator.

---
 rtl/vga_pkg.sv | 35 +++
 rtl/vga_axis_counter.sv | 56 +++++
 rtl/vga_timing.sv | 143 ++++++++++++++
 tb/tb_vga_timing.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 raster timing, derived sync boundaries and shared types.
package vga_pkg;

  localparam int   H_ACTIVE = 640;
  localparam int   H_FP     = 16;
  localparam int   H_SYNC   = 96;
  localparam int   H_BP     = 48;
  localparam int   V_ACTIVE = 480;
  localparam int   V_FP     = 10;
  localparam int   V_SYNC   = 2;
  localparam int   V_BP     = 33;
  localparam logic SYNC_POL = 1'b0;
  localparam int   CLK_DIV  = 1;

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  typedef logic [9:0]  pos_x_t;
  typedef logic [8:0]  pos_y_t;
  typedef logic [31:0] frame_t;
  typedef logic [9:0]  axis_cnt_t;

  // Vertical position clamps to the last active line while in vertical blank.
  function automatic pos_y_t saturate_y(input axis_cnt_t v, input int v_active);
    if (int'(v) < v_active) begin
      return v[8:0];
    end
    return pos_y_t'(v_active - 1);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis (horizontal or vertical). Holds the count and
// reports the next count plus sync/active flags evaluated on that next count, so the
// parent can register them and stay aligned with the counter register.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE,
  parameter int FP     = H_FP,
  parameter int SYNC   = H_SYNC,
  parameter int BP     = H_BP,
  parameter int W      = 10
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] cnt_next_o,
  output logic         wrap_o,
  output logic         in_sync_o,
  output logic         in_active_o
);

  localparam int TOTAL      = ACTIVE + FP + SYNC + BP;
  localparam int SYNC_START = ACTIVE + FP;
  localparam int SYNC_END   = SYNC_START + SYNC;
  localparam logic [W-1:0] LAST = W'(TOTAL - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         at_last;

  // Next count: advance when enabled, wrap back to zero after the last position.
  always_comb begin
    at_last = (cnt_q == LAST);
    cnt_d   = cnt_q;
    if (en_i) begin
      cnt_d = at_last ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o       = cnt_q;
  assign cnt_next_o  = cnt_d;
  assign wrap_o      = en_i && at_last;
  assign in_sync_o   = (int'(cnt_d) >= SYNC_START) && (int'(cnt_d) < SYNC_END);
  assign in_active_o = (int'(cnt_d) < ACTIVE);

endmodule

// File: rtl/vga_timing.sv
// vga_timing: raster timing generator. Provides current and next-clk pixel
// coordinates, sync, visible and a completed-frame counter. Image generators
// register colour from the *_NEXT outputs to line up with the current outputs.
module vga_timing #(
  parameter int   H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int   H_FP     = vga_pkg::H_FP,
  parameter int   H_SYNC   = vga_pkg::H_SYNC,
  parameter int   H_BP     = vga_pkg::H_BP,
  parameter int   V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int   V_FP     = vga_pkg::V_FP,
  parameter int   V_SYNC   = vga_pkg::V_SYNC,
  parameter int   V_BP     = vga_pkg::V_BP,
  parameter logic SYNC_POL = vga_pkg::SYNC_POL,
  parameter int   CLK_DIV  = vga_pkg::CLK_DIV
) (
  input  logic        clk,
  input  logic        rst,
  output logic        pixel_tick,
  output logic        hsync,
  output logic        vsync,
  output logic        visible,
  output logic        visible_NEXT,
  output logic [9:0]  position_x,
  output logic [9:0]  position_x_NEXT,
  output logic [8:0]  position_y,
  output logic [8:0]  position_y_NEXT,
  output logic [31:0] frame
);

  import vga_pkg::*;

  generate
    if (CLK_DIV < 1 || CLK_DIV > 4) begin : g_bad_clk_div
      $error("vga_timing: CLK_DIV must be within 1..4");
    end
    if (H_ACTIVE + H_FP + H_SYNC + H_BP > 1024) begin : g_bad_h_total
      $error("vga_timing: horizontal total exceeds 1024");
    end
    if (V_ACTIVE > 512) begin : g_bad_v_active
      $error("vga_timing: V_ACTIVE exceeds 512");
    end
    if (V_ACTIVE + V_FP + V_SYNC + V_BP > 1024) begin : g_bad_v_total
      $error("vga_timing: vertical total exceeds 1024");
    end
  endgenerate

  localparam logic [1:0] DIV_LAST = 2'(CLK_DIV - 1);

  logic [1:0] div_q;
  logic [1:0] div_d;
  logic       tick;

  axis_cnt_t h_cnt, h_cnt_next, v_cnt, v_cnt_next;
  logic      h_wrap, v_wrap;
  logic      h_sync_next, v_sync_next;
  logic      h_act_next, v_act_next;

  logic   hsync_q, vsync_q, visible_q;
  pos_y_t pos_y_q;
  frame_t frame_q, frame_d;

  // Pixel divider: counts 0..CLK_DIV-1 and ticks on the last count (always ticks when CLK_DIV=1).
  always_comb begin
    tick  = (div_q == DIV_LAST);
    div_d = tick ? 2'd0 : div_q + 2'd1;
  end

  // Divider register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .clk_i       (clk),
    .rst_ni      (rst),
    .en_i        (tick),
    .cnt_o       (h_cnt),
    .cnt_next_o  (h_cnt_next),
    .wrap_o      (h_wrap),
    .in_sync_o   (h_sync_next),
    .in_active_o (h_act_next)
  );

  // The vertical axis only moves when the horizontal axis wraps.
  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .clk_i       (clk),
    .rst_ni      (rst),
    .en_i        (h_wrap),
    .cnt_o       (v_cnt),
    .cnt_next_o  (v_cnt_next),
    .wrap_o      (v_wrap),
    .in_sync_o   (v_sync_next),
    .in_active_o (v_act_next)
  );

  // Frame count advances on the joint h/v wrap (v_wrap already implies h_wrap and tick).
  always_comb begin
    frame_d = v_wrap ? frame_q + 32'd1 : frame_q;
  end

  // Output registers, loaded from the next-state view so they match the counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hsync_q   <= ~SYNC_POL;
      vsync_q   <= ~SYNC_POL;
      visible_q <= 1'b1;
      pos_y_q   <= '0;
      frame_q   <= '0;
    end else begin
      hsync_q   <= h_sync_next ? SYNC_POL : ~SYNC_POL;
      vsync_q   <= v_sync_next ? SYNC_POL : ~SYNC_POL;
      visible_q <= visible_NEXT;
      pos_y_q   <= position_y_NEXT;
      frame_q   <= frame_d;
    end
  end

  assign pixel_tick      = tick;
  assign position_x      = h_cnt;
  assign position_x_NEXT = h_cnt_next;
  assign position_y      = pos_y_q;
  assign position_y_NEXT = saturate_y(v_cnt_next, V_ACTIVE);
  assign visible_NEXT    = h_act_next && v_act_next;
  assign hsync           = hsync_q;
  assign vsync           = vsync_q;
  assign visible         = visible_q;
  assign frame           = frame_q;

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: checks three vga_timing instances (default mode, a small raster,
// and a small raster with CLK_DIV=2 and active-high sync) against an arithmetic
// raster model driven by the number of clock edges since reset release.
module tb_vga_timing;

  localparam int SH_A = 16;
  localparam int SH_F = 2;
  localparam int SH_S = 3;
  localparam int SH_B = 3;
  localparam int SV_A = 10;
  localparam int SV_F = 2;
  localparam int SV_S = 2;
  localparam int SV_B = 3;
  localparam int S_LINE  = SH_A + SH_F + SH_S + SH_B;
  localparam int S_FRAME = S_LINE * (SV_A + SV_F + SV_S + SV_B);

  typedef struct packed {
    logic [9:0]  x;
    logic [8:0]  y;
    logic        hs;
    logic        vs;
    logic        vis;
    logic [31:0] fr;
  } view_t;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic       vis;
  } nview_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic        d_tick, d_hs, d_vs, d_vis, d_visn;
  logic [9:0]  d_x, d_xn;
  logic [8:0]  d_y, d_yn;
  logic [31:0] d_fr;
  logic        s_tick, s_hs, s_vs, s_vis, s_visn;
  logic [9:0]  s_x, s_xn;
  logic [8:0]  s_y, s_yn;
  logic [31:0] s_fr;
  logic        t_tick, t_hs, t_vs, t_vis, t_visn;
  logic [9:0]  t_x, t_xn;
  logic [8:0]  t_y, t_yn;
  logic [31:0] t_fr;

  vga_timing u_def (
    .clk(clk), .rst(rst), .pixel_tick(d_tick), .hsync(d_hs), .vsync(d_vs),
    .visible(d_vis), .visible_NEXT(d_visn), .position_x(d_x), .position_x_NEXT(d_xn),
    .position_y(d_y), .position_y_NEXT(d_yn), .frame(d_fr)
  );

  vga_timing #(
    .H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
    .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B),
    .SYNC_POL(1'b0), .CLK_DIV(1)
  ) u_sml (
    .clk(clk), .rst(rst), .pixel_tick(s_tick), .hsync(s_hs), .vsync(s_vs),
    .visible(s_vis), .visible_NEXT(s_visn), .position_x(s_x), .position_x_NEXT(s_xn),
    .position_y(s_y), .position_y_NEXT(s_yn), .frame(s_fr)
  );

  vga_timing #(
    .H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
    .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B),
    .SYNC_POL(1'b1), .CLK_DIV(2)
  ) u_div (
    .clk(clk), .rst(rst), .pixel_tick(t_tick), .hsync(t_hs), .vsync(t_vs),
    .visible(t_vis), .visible_NEXT(t_visn), .position_x(t_x), .position_x_NEXT(t_xn),
    .position_y(t_y), .position_y_NEXT(t_yn), .frame(t_fr)
  );

  view_t  d_view, s_view, t_view;
  nview_t d_nv, s_nv, t_nv;
  assign d_view = {d_x, d_y, d_hs, d_vs, d_vis, d_fr};
  assign s_view = {s_x, s_y, s_hs, s_vs, s_vis, s_fr};
  assign t_view = {t_x, t_y, t_hs, t_vs, t_vis, t_fr};
  assign d_nv   = {d_xn, d_yn, d_visn};
  assign s_nv   = {s_xn, s_yn, s_visn};
  assign t_nv   = {t_xn, t_yn, t_visn};

  // Clock edges since reset release; the pixel index is k / CLK_DIV.
  longint k = 0;
  always @(posedge clk) begin
    if (!rst) k <= 0;
    else      k <= k + 1;
  end

  // One-register consumers fed from the NEXT outputs.
  nview_t d_copy_q, s_copy_q, t_copy_q;
  always @(posedge clk) begin
    d_copy_q <= d_nv;
    s_copy_q <= s_nv;
    t_copy_q <= t_nv;
  end

  // Raster model: pixel index p -> position, sync, visible and frame number.
  function automatic view_t model(input int ha, input int hf, input int hsy, input int hb,
                                  input int va, input int vf, input int vsy, input int vb,
                                  input logic pol, input longint p);
    view_t  v;
    longint ht, vt, xx, lines, ln;
    ht    = ha + hf + hsy + hb;
    vt    = va + vf + vsy + vb;
    xx    = p % ht;
    lines = p / ht;
    ln    = lines % vt;
    v.x   = 10'(xx);
    v.y   = (ln < va) ? 9'(ln) : 9'(va - 1);
    v.hs  = (xx >= ha + hf && xx < ha + hf + hsy) ? pol : ~pol;
    v.vs  = (ln >= va + vf && ln < va + vf + vsy) ? pol : ~pol;
    v.vis = (xx < ha) && (ln < va);
    v.fr  = 32'(lines / vt);
    return v;
  endfunction

  function automatic view_t m_def(input longint p);
    return model(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, p);
  endfunction
  function automatic view_t m_sml(input longint p);
    return model(SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B, 1'b0, p);
  endfunction
  function automatic view_t m_div(input longint p);
    return model(SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B, 1'b1, p);
  endfunction
  function automatic nview_t nxt(input view_t v);
    return {v.x, v.y, v.vis};
  endfunction
  function automatic view_t reset_view(input logic pol);
    view_t v;
    v.x = '0; v.y = '0; v.hs = ~pol; v.vs = ~pol; v.vis = 1'b1; v.fr = '0;
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (d_view !== reset_view(1'b0)) begin
      n_fail++; $display("FAIL reset_def got=%h exp=%h", d_view, reset_view(1'b0));
    end
    n_tests++;
    if (s_view !== reset_view(1'b0)) begin
      n_fail++; $display("FAIL reset_sml got=%h exp=%h", s_view, reset_view(1'b0));
    end
    n_tests++;
    if (t_view !== reset_view(1'b1)) begin
      n_fail++; $display("FAIL reset_div got=%h exp=%h", t_view, reset_view(1'b1));
    end
    n_tests++;
    if (d_tick !== 1'b1 || t_tick !== 1'b0) begin
      n_fail++; $display("FAIL reset_tick got=%b/%b exp=1/0", d_tick, t_tick);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (d_x !== 10'd0 || d_xn !== 10'd1 || d_y !== 9'd0) begin
      n_fail++; $display("FAIL first_pixel got x=%0d xn=%0d y=%0d exp 0/1/0", d_x, d_xn, d_y);
    end
    @(negedge clk);
    n_tests++;
    if (d_x !== 10'd1) begin
      n_fail++; $display("FAIL second_pixel got x=%0d exp 1", d_x);
    end
    $display("[TB] reset and first pixel checked");
  endtask

  task automatic test_line();
    int hs_low, hs_first, hs_last;
    hs_low = 0; hs_first = -1; hs_last = -1;
    repeat (800) begin
      @(negedge clk);
      n_tests++;
      if (d_view !== m_def(k)) begin
        n_fail++; $display("FAIL line_view k=%0d got=%h exp=%h", k, d_view, m_def(k));
      end
      n_tests++;
      if (d_nv !== nxt(m_def(k + 1))) begin
        n_fail++; $display("FAIL line_next k=%0d got=%h exp=%h", k, d_nv, nxt(m_def(k + 1)));
      end
      if (k < 800 && d_hs === 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(d_x);
        hs_last = int'(d_x);
      end
      if (k == 799) begin
        n_tests++;
        if (d_xn !== 10'd0 || d_yn !== 9'd1) begin
          n_fail++; $display("FAIL line_wrap_next got xn=%0d yn=%0d exp 0/1", d_xn, d_yn);
        end
      end
    end
    n_tests++;
    if (hs_low != 96 || hs_first != 656 || hs_last != 751) begin
      n_fail++;
      $display("FAIL hsync_window got len=%0d first=%0d last=%0d exp 96/656/751",
               hs_low, hs_first, hs_last);
    end
    $display("[TB] one line of default mode checked, hsync low for %0d pixels", hs_low);
  endtask

  task automatic test_frame();
    logic [31:0] prev_fr;
    int          vs_low;
    prev_fr = s_fr;
    vs_low  = 0;
    repeat (2 * S_FRAME) begin
      @(negedge clk);
      n_tests++;
      if (s_view !== m_sml(k)) begin
        n_fail++; $display("FAIL frame_view k=%0d got=%h exp=%h", k, s_view, m_sml(k));
      end
      n_tests++;
      if (s_nv !== nxt(m_sml(k + 1))) begin
        n_fail++; $display("FAIL frame_next k=%0d got=%h exp=%h", k, s_nv, nxt(m_sml(k + 1)));
      end
      if (s_vs === 1'b0) vs_low++;
      if (s_fr !== prev_fr) begin
        n_tests++;
        if ((k % S_FRAME) != 0 || s_fr !== prev_fr + 32'd1) begin
          n_fail++; $display("FAIL frame_step k=%0d got=%0d prev=%0d", k, s_fr, prev_fr);
        end
      end
      prev_fr = s_fr;
    end
    n_tests++;
    if (vs_low != 2 * SV_S * S_LINE) begin
      n_fail++; $display("FAIL vsync_cycles got=%0d exp=%0d", vs_low, 2 * SV_S * S_LINE);
    end
    $display("[TB] two small frames checked, frame now %0d", s_fr);
  endtask

  task automatic test_clk_div();
    repeat (200) begin
      @(negedge clk);
      n_tests++;
      if (t_tick !== ((k % 2) == 1)) begin
        n_fail++; $display("FAIL div_tick k=%0d got=%b exp=%b", k, t_tick, ((k % 2) == 1));
      end
      n_tests++;
      if (t_view !== m_div(k / 2)) begin
        n_fail++; $display("FAIL div_view k=%0d got=%h exp=%h", k, t_view, m_div(k / 2));
      end
      n_tests++;
      if (t_nv !== nxt(m_div((k + 1) / 2))) begin
        n_fail++;
        $display("FAIL div_next k=%0d got=%h exp=%h", k, t_nv, nxt(m_div((k + 1) / 2)));
      end
    end
    $display("[TB] CLK_DIV=2 instance checked over 200 clks");
  endtask

  task automatic test_random_reset();
    for (int it = 0; it < 6; it++) begin
      int unsigned wait_cyc;
      if (it == 0) begin
        wait_cyc = int'((300 - (k % 800) + 800) % 800);
        if (wait_cyc == 0) wait_cyc = 800;
      end else begin
        wait_cyc = $urandom_range(20, 900);
      end
      repeat (wait_cyc) @(posedge clk);
      #2;
      if (it == 0) begin
        n_tests++;
        if (d_x !== 10'd300) begin
          n_fail++; $display("FAIL pre_reset_x got=%0d exp=300", d_x);
        end
      end
      rst = 1'b0;
      #1;
      n_tests++;
      if (d_view !== reset_view(1'b0)) begin
        n_fail++; $display("FAIL async_reset_def got=%h exp=%h", d_view, reset_view(1'b0));
      end
      n_tests++;
      if (s_view !== reset_view(1'b0)) begin
        n_fail++; $display("FAIL async_reset_sml got=%h exp=%h", s_view, reset_view(1'b0));
      end
      n_tests++;
      if (t_view !== reset_view(1'b1)) begin
        n_fail++; $display("FAIL async_reset_div got=%h exp=%h", t_view, reset_view(1'b1));
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (d_view !== reset_view(1'b0) || s_view !== reset_view(1'b0)) begin
        n_fail++; $display("FAIL reset_hold got=%h/%h", d_view, s_view);
      end
      rst = 1'b1;
      repeat (3) begin
        @(negedge clk);
        n_tests++;
        if (d_view !== m_def(k) || s_view !== m_sml(k) || t_view !== m_div(k / 2)) begin
          n_fail++;
          $display("FAIL post_reset k=%0d got=%h/%h/%h exp=%h/%h/%h", k, d_view, s_view,
                   t_view, m_def(k), m_sml(k), m_div(k / 2));
        end
      end
      $display("[TB] reset %0d asserted after %0d clks", it, wait_cyc);
    end
  endtask

  task automatic test_one_reg_consumer();
    @(negedge clk);
    repeat (2 * S_FRAME + 8) begin
      @(negedge clk);
      n_tests++;
      if (d_copy_q !== {d_x, d_y, d_vis}) begin
        n_fail++; $display("FAIL consumer_def got=%h exp=%h", d_copy_q, {d_x, d_y, d_vis});
      end
      n_tests++;
      if (s_copy_q !== {s_x, s_y, s_vis}) begin
        n_fail++; $display("FAIL consumer_sml got=%h exp=%h", s_copy_q, {s_x, s_y, s_vis});
      end
      n_tests++;
      if (t_copy_q !== {t_x, t_y, t_vis}) begin
        n_fail++; $display("FAIL consumer_div got=%h exp=%h", t_copy_q, {t_x, t_y, t_vis});
      end
    end
    $display("[TB] one-register consumers checked over two small frames");
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_clk_div();
    test_random_reset();
    test_one_reg_consumer();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
